// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, LSB first, through a single 1-bit full adder.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input. When sub=1 the
// block computes a - b as a + ~b + 1.
// Result, carry-out and signed overflow appear WIDTH cycles after start is accepted.

module structuralFullAdder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  logic g;
  logic t;

  xor u_p  (p, x, y);
  xor u_s  (s, p, ci);
  and u_g  (g, x, y);
  and u_t  (t, p, ci);
  or  u_co (co, g, t);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic             carry_msb;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             fa_s;
  logic             fa_co;

  // Select the operand B and carry-in that get latched when start is accepted.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  structuralFullAdder u_fa (
    .x  (a_reg[0]),
    .y  (b_reg[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // The sequencer. a_reg also serves as the result shift register: each sum bit
  // enters at the MSB end as the operand bit leaves at the LSB end.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      carry_msb <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b_eff;
            carry <= cin_eff;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_reg <= {fa_s, a_reg[WIDTH-1:1]};
          b_reg <= b_reg >> 1;
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (cnt == PRE_LAST) begin
            carry_msb <= fa_co;
          end
          if (cnt == LAST) begin
            sum      <= {fa_s, a_reg[WIDTH-1:1]};
            cout     <= fa_co;
            overflow <= carry_msb ^ fa_co;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl (WIDTH=8). Compares the DUT against an
// integer-arithmetic reference model, using directed and random operations.

module tb_serial_adder_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
`endif
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. Returns {overflow, cout, sum[7:0]}, computed with plain integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic mc, input logic ms);
    int unsigned utot;
    int          stot;
    logic [7:0]  eb;
    int          ec;
    eb   = ms ? ~mb : mb;
    ec   = ms ? 1 : int'(mc);
    utot = int'(ma) + int'(eb) + ec;
    stot = int'($signed(ma)) + int'($signed(eb)) + ec;
    model = {((stot > 127) || (stot < -128)), utot[8], utot[7:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Pulses start for one edge, then scrambles the operands.
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb2,
                               input logic tc, input logic ts);
    a = ta; b = tb2; cin = tc; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ts;
`endif
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'($urandom);
`endif
  endtask

  // Counts cycles from the first negedge after accept until done, bounded.
  task automatic waitDone(output int cyc, output int bcyc);
    cyc = 0; bcyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) bcyc++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic runOp(input string name, input logic [7:0] ta, input logic [7:0] tb2,
                       input logic tc, input logic ts);
    logic [9:0] exp;
    int cyc, bcyc;
    exp = model(ta, tb2, tc, ts);
    applyStimulus(ta, tb2, tc, ts);
    waitDone(cyc, bcyc);
    checkOutput({name, " latency"}, cyc, 8);
    checkOutput({name, " busy_cycles"}, bcyc, 8);
    checkOutput({name, " busy_at_done"}, {31'd0, busy}, 0);
    checkOutput({name, " sum"}, {24'd0, sum}, {24'd0, exp[7:0]});
    checkOutput({name, " cout"}, {31'd0, cout}, {31'd0, exp[8]});
    checkOutput({name, " overflow"}, {31'd0, overflow}, {31'd0, exp[9]});
    @(negedge clk);
  endtask

  initial begin
    int dcount;
    int gap;
    logic [9:0] e1;
    logic [9:0] e2;
    logic [7:0] ra;
    logic [7:0] rb;

    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset busy", {31'd0, busy}, 0);
    checkOutput("reset done", {31'd0, done}, 0);
    checkOutput("reset sum", {24'd0, sum}, 0);
    checkOutput("reset cout", {31'd0, cout}, 0);
    checkOutput("reset overflow", {31'd0, overflow}, 0);

    // Start on the first edge after reset is released.
    reset = 1'b0;
    runOp("op_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0);
    checkOutput("pulse_width done", {31'd0, done}, 0);
    repeat (3) @(negedge clk);
    checkOutput("hold sum", {24'd0, sum}, 32'h96);
    checkOutput("hold overflow", {31'd0, overflow}, 1);

    runOp("op_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    runOp("op_7f_00_c1", 8'h7F, 8'h00, 1'b1, 1'b0);

    // Re-pulse start mid-RUN with different operands.
    $display("[TB] start re-pulse during RUN");
    e1 = model(8'h33, 8'h44, 1'b1, 1'b0);
    applyStimulus(8'h33, 8'h44, 1'b1, 1'b0);
    @(negedge clk);
    a = 8'hEE; b = 8'hDD; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    for (int k = 0; k < 16; k++) begin
      if (done === 1'b1) dcount++;
      @(negedge clk);
    end
    checkOutput("restart done_count", dcount, 1);
    checkOutput("restart sum", {24'd0, sum}, {24'd0, e1[7:0]});
    checkOutput("restart cout", {31'd0, cout}, {31'd0, e1[8]});

    // Reset in the 4th RUN cycle aborts the operation.
    $display("[TB] reset during RUN");
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort busy", {31'd0, busy}, 0);
    checkOutput("abort done", {31'd0, done}, 0);
    checkOutput("abort sum", {24'd0, sum}, 0);
    checkOutput("abort cout", {31'd0, cout}, 0);
    checkOutput("abort overflow", {31'd0, overflow}, 0);
    dcount = 0;
    for (int k = 0; k < 12; k++) begin
      if (done === 1'b1) dcount++;
      @(negedge clk);
    end
    checkOutput("abort no_done", dcount, 0);
    runOp("after_abort", 8'hA5, 8'h5A, 1'b1, 1'b0);

    // Start held high across DONE: back-to-back operations.
    $display("[TB] back-to-back");
    e1 = model(8'h81, 8'h82, 1'b0, 1'b0);
    e2 = model(8'h40, 8'h40, 1'b0, 1'b0);
    a = 8'h81; b = 8'h82; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    gap = 0;
    while (done !== 1'b1 && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    checkOutput("b2b first sum", {24'd0, sum}, {24'd0, e1[7:0]});
    checkOutput("b2b first cout", {31'd0, cout}, {31'd0, e1[8]});
    a = 8'h40; b = 8'h40;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b no_bubble busy", {31'd0, busy}, 1);
    gap = 1;
    while (done !== 1'b1 && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    checkOutput("b2b gap", gap, 9);
    checkOutput("b2b second sum", {24'd0, sum}, {24'd0, e2[7:0]});
    checkOutput("b2b second overflow", {31'd0, overflow}, {31'd0, e2[9]});
    @(negedge clk);

    // Random operations.
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      runOp($sformatf("rand%0d", i), ra, rb, 1'($urandom), 1'b0);
    end

`ifdef SERIAL_ADDER_SUB_EN
    runOp("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1);
    runOp("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      runOp($sformatf("rsub%0d", i), ra, rb, 1'($urandom), 1'b1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an addition.
REQ-005 SHALL have port a  input  WIDTH  operand A.
REQ-006 SHALL have port b  input  WIDTH  operand B.
REQ-007 SHALL have port cin  input  1  initial carry-in.
REQ-008 SHALL have port busy  output  1  high while bits are being processed.
REQ-009 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-010 SHALL have port sum  output  WIDTH  result; held stable from the done pulse until the next accepted start.
REQ-011 SHALL have port cout  output  1  final carry-out.
REQ-012 SHALL have port overflow  output  1  signed overflow, defined as the carry into MSB XOR cout.

Function
REQ-013 SHALL perform the addition bit-serially through exactly one 1-bit structuralFullAdder instance, LSB first, with no other adder logic.
REQ-014 SHALL have FSM states IDLE, RUN and DONE.
REQ-015 SHALL accept start only in IDLE or DONE: at accept edge E0 it latches a, b and cin, clears the bit counter and enters RUN.
REQ-016 SHALL ignore a, b and cin after E0 until the next accept.
REQ-017 SHALL process bit i at edge E(i+1) while in RUN: the full-adder sum is shifted into the result register, its carry into the carry register, and the counter increments.
REQ-018 SHALL transition RUN->DONE at edge E(WIDTH), so done=1 exactly WIDTH cycles after E0, for one cycle.
REQ-019 SHALL transition DONE->RUN if start=1 in DONE (back-to-back accept, no idle bubble), otherwise DONE->IDLE.
REQ-020 SHALL drive busy=1 only in RUN, so busy and done are never high together.
REQ-021 SHALL ignore start while in RUN; the operation in progress is unaffected.
REQ-022 SHALL update sum, cout and overflow only at edge E(WIDTH); between operations they hold their last values.
REQ-023 SHALL wrap arithmetically modulo 2^WIDTH, with the carry beyond the MSB reported only on cout.
REQ-024 SHALL record the carry into the MSB at edge E(WIDTH-1) for the overflow calculation.

Reset
REQ-025 SHALL, when reset=1 at a clock edge, force state=IDLE, counter=0, carry=0, busy=0, done=0, sum=0, cout=0, overflow=0.
REQ-026 SHALL take reset priority over start and over any operation in progress: a reset during RUN aborts the operation, and no done pulse follows.
REQ-027 SHALL accept start on the first edge after reset deasserts.

Configuration
REQ-028 SHALL, when SERIAL_ADDER_SUB_EN is defined, add port sub (input, 1 bit), latched at accept; sub=1 computes a - b as a + ~b + 1, with cin ignored and the effective carry-in forced to 1.
REQ-029 SHALL, when SERIAL_ADDER_SUB_EN is undefined, have no sub port and perform addition only with the supplied cin.

Verification (WIDTH=8)
REQ-030 SHALL cover: a=0x5A, b=0x3C, cin=0, start pulse -> done 8 cycles after accept, sum=0x96, cout=0, overflow=1, busy high for exactly 8 cycles.
REQ-031 SHALL cover: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0; then a=0x7F, b=0x00, cin=1 -> sum=0x80, overflow=1.
REQ-032 SHALL cover: start re-pulsed with different operands mid-RUN -> ignored, first result correct, single done pulse.
REQ-033 SHALL cover: reset asserted at the 4th RUN cycle -> next cycle all outputs 0, state IDLE, no done; a fresh start then completes correctly.
REQ-034 SHALL cover: start held high across DONE -> second operation begins with no idle cycle; done pulses exactly 9 cycles apart (one DONE cycle plus 8 RUN cycles).
REQ-035 SHALL cover, with SERIAL_ADDER_SUB_EN defined: sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1; and a=0x80, b=0x01 -> sum=0x7F, overflow=1.
